mole_game_core: RTL and testbench

Parametrised whack-a-mole game engine for an N-hole board.
- Inputs: debounced hit levels, one per hole, from the tilt/button front end.
- Outputs: one-hot mole visibility, score, lives and game state, consumed by the VGA renderer and the board displays.
- Adds over the fixed 4-hole engine: configurable hole count, real-time millisecond timing, pseudo-random mole selection with no immediate repeats, wrong-hole penalties, and optional difficulty ramp.

---
 rtl/mole_game_pkg.sv | 32 +++
 rtl/mole_game_core_ms_timer.sv | 50 +++++
 rtl/mole_game_core.sv | 180 ++++++++++++++++++
 tb/tb_mole_game_core.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_game_pkg.sv
// ============================================================================
// Module   : mole_game_pkg
// Brief    : Shared state encoding, LFSR constants and helpers for the
//            whack-a-mole engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mole_game_pkg;

    localparam int STATE_W = 3;
    localparam int MS_W    = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        GAP        = 3'd1,
        SHOW       = 3'd2,
        END_SCREEN = 3'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting register sit at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mole_game_core_ms_timer.sv
// ============================================================================
// Module   : ms_timer
// Brief    : Prescaler plus millisecond down-counter with a one-cycle done.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ms_timer #(
    parameter int TICK_DIV = 100000,
    parameter int MS_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart_i,
    input  logic [MS_W-1:0] load_ms_i,
    output logic            done_o
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]   pre_q;
    logic [MS_W-1:0] ms_q;
    logic            w_tick;

    assign w_tick = (pre_q == PRE_LAST);
    // Fires on the last cycle of the last millisecond so the consumer
    // changes state exactly load*TICK_DIV cycles after restart.
    assign done_o = w_tick && (ms_q == MS_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else if (restart_i) begin
            pre_q <= '0;
            ms_q  <= load_ms_i;
        end else if (ms_q != '0) begin
            if (w_tick) begin
                pre_q <= '0;
                ms_q  <= ms_q - MS_W'(1);
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mole_game_core.sv
// ============================================================================
// Module   : mole_game_core
// Brief    : N-hole whack-a-mole engine: hit edge detect, LFSR mole picker,
//            game FSM, score and lives. Define MOLE_SPEEDUP_EN for the
//            score-driven shrinking visible window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mole_game_core
    import mole_game_pkg::*;
#(
    parameter int NUM_MOLES     = 4,
    parameter int SCORE_W       = 7,
    parameter int LIVES         = 3,
    parameter int TICK_DIV      = 100000,
    parameter int GAP_MS        = 250,
    parameter int SHOW_MS       = 1000,
    parameter int MIN_SHOW_MS   = 300,
    parameter int SPEED_STEP_MS = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_MOLES-1:0] hit,
    output logic [NUM_MOLES-1:0] mole,
    output logic [SCORE_W-1:0]   score,
    output logic [1:0]           lives,
    output logic [STATE_W-1:0]   state
);

    localparam logic [1:0]      LIVES_INIT = 2'(LIVES);
    localparam logic [MS_W-1:0] GAP_LD     = MS_W'(GAP_MS);

    if (NUM_MOLES < 2 || NUM_MOLES > 8 || LIVES < 1 || LIVES > 3 ||
        MIN_SHOW_MS < 0 || SPEED_STEP_MS < 0) begin : g_bad_cfg
        $error("mole_game_core: illegal parameter set");
    end

    logic [NUM_MOLES-1:0] hit_q, mole_q, mole_d;
    logic                 arm_q;
    logic [15:0]          lfsr_q;
    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [1:0]           lives_q, lives_d;
    logic [IDX_W-1:0]     prev_q, prev_d;

    logic [NUM_MOLES-1:0] w_rise;
    logic                 w_any, w_good, w_bad;
    logic                 w_restart, w_done;
    logic [MS_W-1:0]      w_load, w_window;
    logic [7:0]           w_raw;
    logic [IDX_W-1:0]     w_idx;

    // arm_q masks the first cycle after reset so a level held through
    // reset is not mistaken for a fresh press.
    assign w_rise = arm_q ? (hit & ~hit_q) : '0;
    assign w_any  = |w_rise;
    assign w_good = |(w_rise & mole_q);
    assign w_bad  = |(w_rise & ~mole_q);

    always_comb begin
        w_raw = lfsr_q[7:0] % 8'(NUM_MOLES);
        if (w_raw[IDX_W-1:0] == prev_q)
            w_idx = (w_raw == 8'(NUM_MOLES - 1)) ? '0 : w_raw[IDX_W-1:0] + IDX_W'(1);
        else
            w_idx = w_raw[IDX_W-1:0];
    end

`ifdef MOLE_SPEEDUP_EN
    logic [31:0] w_cut;
    always_comb begin
        w_cut = 32'(score_q >> 3) * 32'(SPEED_STEP_MS);
        if (32'(SHOW_MS) < 32'(MIN_SHOW_MS) + w_cut)
            w_window = MS_W'(MIN_SHOW_MS);
        else
            w_window = MS_W'(32'(SHOW_MS) - w_cut);
    end
`else
    assign w_window = MS_W'(SHOW_MS);
`endif

    always_comb begin
        state_d   = state_q;
        mole_d    = mole_q;
        score_d   = score_q;
        lives_d   = lives_q;
        prev_d    = prev_q;
        w_restart = 1'b0;
        w_load    = GAP_LD;
        case (state_q)
            IDLE: begin
                mole_d = '0;
                if (w_any) begin
                    score_d   = '0;
                    lives_d   = LIVES_INIT;
                    state_d   = GAP;
                    w_restart = 1'b1;
                end
            end
            GAP: begin
                if (w_done) begin
                    mole_d    = NUM_MOLES'(1) << w_idx;
                    prev_d    = w_idx;
                    state_d   = SHOW;
                    w_restart = 1'b1;
                    w_load    = w_window;
                end
            end
            SHOW: begin
                // A correct rise beats both wrong rises and a same-cycle timeout.
                if (w_good) begin
                    if (score_q != '1)
                        score_d = score_q + SCORE_W'(1);
                    mole_d    = '0;
                    state_d   = GAP;
                    w_restart = 1'b1;
                end else if (w_bad || w_done) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        mole_d  = '0;
                        state_d = END_SCREEN;
                    end else if (w_done) begin
                        mole_d    = '0;
                        state_d   = GAP;
                        w_restart = 1'b1;
                    end
                end
            end
            END_SCREEN: begin
                mole_d = '0;
                if (w_any) begin
                    lives_d = LIVES_INIT;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q   <= '0;
            arm_q   <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            state_q <= IDLE;
            mole_q  <= '0;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            prev_q  <= IDX_W'(NUM_MOLES);
        end else begin
            hit_q   <= hit;
            arm_q   <= 1'b1;
            lfsr_q  <= lfsr_next(lfsr_q);
            state_q <= state_d;
            mole_q  <= mole_d;
            score_q <= score_d;
            lives_q <= lives_d;
            prev_q  <= prev_d;
        end
    end

    ms_timer #(
        .TICK_DIV (TICK_DIV),
        .MS_W     (MS_W)
    ) u_timer (
        .clk       (clk),
        .rst       (reset),
        .restart_i (w_restart),
        .load_ms_i (w_load),
        .done_o    (w_done)
    );

    assign mole  = mole_q;
    assign score = score_q;
    assign lives = lives_q;
    assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mole_game_core.sv
// ============================================================================
// Module   : tb_mole_game_core
// Brief    : Self-checking bench for mole_game_core against a behavioural
//            game model; honours MOLE_SPEEDUP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mole_game_core;

    localparam int NM     = 4;
    localparam int TD     = 10;
    localparam int GAPMS  = 2;
    localparam int SHOWMS = 5;
    localparam int LV     = 3;
    localparam int SW     = 7;
    localparam int SMAX   = (1 << SW) - 1;
`ifdef MOLE_SPEEDUP_EN
    localparam int MINMS = 3, STEPMS = 1;
    localparam int EXP_W8 = 40, EXP_W16 = 30, EXP_W24 = 30;
`else
    localparam int MINMS = 300, STEPMS = 50;
    localparam int EXP_W8 = 50, EXP_W16 = 50, EXP_W24 = 50;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NM-1:0] hit = '0;
    logic [NM-1:0] mole;
    logic [SW-1:0] score;
    logic [1:0]    lives;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mole_game_core #(
        .NUM_MOLES(NM), .SCORE_W(SW), .LIVES(LV), .TICK_DIV(TD),
        .GAP_MS(GAPMS), .SHOW_MS(SHOWMS), .MIN_SHOW_MS(MINMS),
        .SPEED_STEP_MS(STEPMS)
    ) dut (
        .clk(clk), .reset(reset), .hit(hit),
        .mole(mole), .score(score), .lives(lives), .state(state)
    );

    // Game-level model: phase, remaining cycles of the current interval,
    // index of the lit hole (-1 = none), and the pseudo-random sequence.
    int            m_state, m_mole, m_prev, m_score, m_lives, m_left, m_lfsr;
    logic [NM-1:0] m_hitq;
    bit            m_arm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NM-1:0] mvec();
        return (m_mole >= 0) ? NM'(1 << m_mole) : '0;
    endfunction

    function automatic int window_ms();
`ifdef MOLE_SPEEDUP_EN
        int w;
        w = SHOWMS - (m_score / 8) * STEPMS;
        return (w < MINMS) ? MINMS : w;
`else
        return SHOWMS;
`endif
    endfunction

    function automatic void model_reset();
        m_state = 0; m_mole = -1; m_prev = NM; m_score = 0; m_lives = LV;
        m_left = 0; m_lfsr = 'hACE1; m_hitq = '0; m_arm = 1'b0;
    endfunction

    function automatic void model_step(input logic [NM-1:0] h);
        logic [NM-1:0] rise, lit;
        bit            expire;
        int            idx, fb;
        rise   = m_arm ? (h & ~m_hitq) : '0;
        lit    = mvec();
        expire = (m_left == 1);
        if (m_left > 0) m_left--;
        case (m_state)
            0: if (rise != 0) begin
                m_score = 0; m_lives = LV; m_state = 1; m_left = GAPMS * TD;
            end
            1: if (expire) begin
                idx = (m_lfsr % 256) % NM;
                if (idx == m_prev) idx = (idx + 1) % NM;
                m_mole = idx; m_prev = idx; m_state = 2;
                m_left = window_ms() * TD;
            end
            2: if ((rise & lit) != 0) begin
                if (m_score < SMAX) m_score++;
                m_mole = -1; m_state = 1; m_left = GAPMS * TD;
            end else if ((rise & ~lit) != 0 || expire) begin
                m_lives--;
                if (m_lives == 0) begin
                    m_mole = -1; m_state = 3;
                end else if (expire) begin
                    m_mole = -1; m_state = 1; m_left = GAPMS * TD;
                end
            end
            3: if (rise != 0) begin
                m_state = 0; m_lives = LV;
            end
            default: ;
        endcase
        m_hitq = h;
        m_arm  = 1'b1;
        fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
    endfunction

    task automatic step(input logic [NM-1:0] h);
        hit = h;
        model_step(h);
        @(posedge clk);
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("mole", 32'(mole), 32'(mvec()));
        chk("score", 32'(score), 32'(m_score));
        chk("lives", 32'(lives), 32'(m_lives));
    endtask

    task automatic wait_show();
        int n;
        n = 0;
        while (state != 3'd2 && n < 500) begin
            step('0);
            n++;
        end
        chk("wait_show", 32'(state == 3'd2), 32'd1);
    endtask

    task automatic measure_show(output int n);
        wait_show();
        n = 0;
        while (state == 3'd2 && n < 1000) begin
            step('0);
            n++;
        end
    endtask

    task automatic hit_lit();
        wait_show();
        step('0);
        step(mvec());
    endtask

    task automatic start_game();
        int tries;
        tries = 0;
        while ((m_state == 0 || m_state == 3) && tries < 6) begin
            step('0);
            step(NM'(1));
            tries++;
        end
        chk("start_game", 32'(state == 3'd1 || state == 3'd2), 32'd1);
    endtask

    initial begin
        int            n, r, picks;
        logic [NM-1:0] l, h, last_pick, prev_obs;

        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mole", 32'(mole), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_lives", 32'(lives), 32'(LV));
        reset = 1'b0;

        // Start and first mole.
        step('0);
        step(4'b0100);
        chk("start_state", 32'(state), 32'd1);
        n = 0;
        while (state == 3'd1 && n < 200) begin
            step(4'b0100);
            n++;
        end
        chk("gap_len", 32'(n), 32'(GAPMS * TD));
        chk("show_state", 32'(state), 32'd2);
        chk("first_onehot", 32'($onehot(mole)), 32'd1);

        // Correct hit together with a wrong one.
        step('0);
        l = mvec();
        step(l | {l[NM-2:0], l[NM-1]});
        chk("hit_score", 32'(score), 32'd1);
        chk("hit_mole", 32'(mole), 32'd0);
        chk("hit_state", 32'(state), 32'd1);
        chk("hit_lives", 32'(lives), 32'd3);

        // Wrong hit, then timeout on the same window.
        wait_show();
        step('0);
        l = mvec();
        step({l[NM-2:0], l[NM-1]});
        chk("wrong_lives", 32'(lives), 32'd2);
        chk("wrong_mole", 32'(mole), 32'(l));
        n = 2;
        while (state == 3'd2 && n < 1000) begin
            step('0);
            n++;
        end
        chk("show_len", 32'(n), 32'(SHOWMS * TD));
        chk("timeout_lives", 32'(lives), 32'd1);

        // Game over and restart.
        measure_show(n);
        chk("over_state", 32'(state), 32'd3);
        chk("over_mole", 32'(mole), 32'd0);
        chk("over_lives", 32'(lives), 32'd0);
        step('0);
        step(NM'(1));
        chk("to_idle", 32'(state), 32'd0);
        chk("idle_score_hold", 32'(score), 32'd1);
        step('0);
        step(NM'(1));
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_lives", 32'(lives), 32'd3);

        // Window length versus score.
        for (int i = 0; i < 8; i++) hit_lit();
        measure_show(n);
        chk("win_after8", 32'(n), 32'(EXP_W8));
        for (int i = 0; i < 8; i++) hit_lit();
        measure_show(n);
        chk("win_after16", 32'(n), 32'(EXP_W16));
        for (int i = 0; i < 8; i++) hit_lit();
        measure_show(n);
        chk("win_after24", 32'(n), 32'(EXP_W24));
        chk("ramp_end", 32'(state), 32'd3);

        // Asynchronous reset mid-SHOW with a hit held through release.
        start_game();
        wait_show();
        #3;
        reset = 1'b1;
        hit   = NM'(1);
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_mole", 32'(mole), 32'd0);
        chk("async_score", 32'(score), 32'd0);
        chk("async_lives", 32'(lives), 32'(LV));
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(NM'(1));
        chk("held_no_event", 32'(state), 32'd0);
        step('0);
        step(NM'(1));
        chk("rearm_event", 32'(state), 32'd1);

        // Random play; every new mole must differ from the previous one.
        picks = 0;
        n = 0;
        h = '0;
        last_pick = '0;
        prev_obs = mole;
        while (picks < 200 && n < 40000) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) h = NM'($urandom_range(0, (1 << NM) - 1));
            else if (r < 12) h = '0;
            else if (r < 15 && m_state == 2) h = mvec();
            step(h);
            if (mole != '0 && prev_obs == '0) begin
                picks++;
                if (last_pick != '0) chk("no_repeat", 32'(mole == last_pick), 32'd0);
                last_pick = mole;
            end
            prev_obs = mole;
            n++;
        end
        chk("pick_count", 32'(picks >= 200), 32'd1);

        // Score saturation.
        start_game();
        for (int i = 0; i < SMAX + 3; i++) hit_lit();
        chk("score_sat", 32'(score), 32'(SMAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
